// File: rtl/defender_input_pkg.sv
// Shared encodings for the Defender input-conditioning stage:
// control modes, joystick bit positions, stick direction and FSM states.
package defender_input_pkg;

  localparam int unsigned JOY_W = 16;

  // Control mode encodings (2'b11 behaves as MODE1)
  localparam logic [1:0] MODE1   = 2'b00;
  localparam logic [1:0] MODE2   = 2'b01;
  localparam logic [1:0] CABINET = 2'b10;

  // Bit positions within the merged joystick word
  localparam int unsigned J_R       = 0;
  localparam int unsigned J_L       = 1;
  localparam int unsigned J_D       = 2;
  localparam int unsigned J_U       = 3;
  localparam int unsigned J_FIRE_A  = 4;
  localparam int unsigned J_FIRE_B  = 5;
  localparam int unsigned J_FIRE_C  = 6;
  localparam int unsigned J_FIRE_D  = 7;
  localparam int unsigned J_FIRE_E  = 8;
  localparam int unsigned J_START1  = 9;
  localparam int unsigned J_START2  = 10;
  localparam int unsigned J_COIN    = 11;
  localparam int unsigned J_ADVANCE = 12;
  localparam int unsigned J_AUTOUP  = 13;
  localparam int unsigned J_HSRESET = 14;
  localparam int unsigned J_PAUSE   = 15;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_LOCK  = 2'd2
  } coin_state_t;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_REV    = 2'd1,
    M_WAIT   = 2'd2,
    M_THRUST = 2'd3
  } m2_state_t;

endpackage

// File: rtl/debounce_bank.sv
// Bank of W debouncers sharing one free-running prescaler.
// Ports:
//   clk_sys - system clock
//   reset   - synchronous reset, active-high
//   raw     - raw input bits
//   deb     - debounced bits (registered)
// A sample is taken each time the prescaler wraps; a debounced bit only
// changes when the new sample agrees with the previous one.
module debounce_bank #(
  parameter int unsigned W        = 16,
  parameter int unsigned DEB_BITS = 16
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb
);

  logic [DEB_BITS-1:0] presc;
  logic [W-1:0]        samp;
  logic                tick_c;
  logic [W-1:0]        agree_c;

  // Tick coincides with the prescaler wrapping back to zero
  assign tick_c  = (presc == '1);
  assign agree_c = ~(raw ^ samp);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc <= '0;
      samp  <= '0;
      deb   <= '0;
    end else begin
      presc <= presc + DEB_BITS'(1);
      if (tick_c) begin
        samp <= raw;
        deb  <= (deb & ~agree_c) | (raw & agree_c);
      end
    end
  end

endmodule

// File: rtl/defender_input_cond.sv
// Input conditioning for the Defender core: debounced buttons, frame-counted
// coin pulse and Mode 2 automatic reverse/thrust, packed into in0/in1/in2.
// Ports:
//   clk_sys      - system clock
//   reset        - synchronous reset, active-high
//   joy          - raw merged joystick bits, active-high
//   mode         - 00 Mode 1, 01 Mode 2, 10 Cabinet, 11 as Mode 1
//   facing_right - ship facing from the core
//   vblank       - video vblank; rising edge is the frame tick
//   in0/in1/in2  - registered Defender input bytes
module defender_input_cond
  import defender_input_pkg::*;
#(
  parameter int unsigned DEB_BITS    = 16,
  parameter int unsigned COIN_FRAMES = 3,
  parameter int unsigned REV_FRAMES  = 2,
  parameter int unsigned WAIT_FRAMES = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [JOY_W-1:0] joy,
  input  logic [1:0]       mode,
  input  logic             facing_right,
  input  logic             vblank,
  output logic [7:0]       in0,
  output logic [7:0]       in1,
  output logic [7:0]       in2
);

  localparam int unsigned CW = (COIN_FRAMES > 0) ? $clog2(COIN_FRAMES + 1) : 1;
  localparam int unsigned RW = (REV_FRAMES  > 0) ? $clog2(REV_FRAMES  + 1) : 1;
  localparam int unsigned WW = (WAIT_FRAMES > 0) ? $clog2(WAIT_FRAMES + 1) : 1;

  logic [JOY_W-1:0] deb;
  logic             vblank_d;
  logic             coin_d;
  logic [1:0]       mode_d;

  coin_state_t      c_state, c_next;
  logic [CW-1:0]    c_cnt, c_cnt_next;
  m2_state_t        m_state, m_next;
  logic [RW-1:0]    rcnt, rcnt_next;
  logic [WW-1:0]    wcnt, wcnt_next;

  logic             frame_c;
  logic             coin_rise_c;
  dir_t             dir_c;
  logic             dir_match_c;
  logic             dir_opp_c;
  logic             thrust_c;
  logic             rev_c;
  logic [7:0]       in0_c, in1_c, in2_c;
  logic             unused_pause;

  debounce_bank #(
    .W        (JOY_W),
    .DEB_BITS (DEB_BITS)
  ) u_debounce (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (joy),
    .deb     (deb)
  );

  assign unused_pause = deb[J_PAUSE];
  assign frame_c      = vblank & ~vblank_d;
  assign coin_rise_c  = deb[J_COIN] & ~coin_d;

  // Stick direction request and its relation to the ship facing
  always_comb begin
    dir_c = NONE;
    if (deb[J_R] && !deb[J_L])      dir_c = RIGHT;
    else if (deb[J_L] && !deb[J_R]) dir_c = LEFT;
  end

  assign dir_match_c = ((dir_c == RIGHT) &&  facing_right) || ((dir_c == LEFT) && !facing_right);
  assign dir_opp_c   = ((dir_c == RIGHT) && !facing_right) || ((dir_c == LEFT) &&  facing_right);

  // Coin FSM: one frame-counted pulse per press
  always_comb begin
    c_next     = c_state;
    c_cnt_next = c_cnt;
    case (c_state)
      C_IDLE: begin
        if (coin_rise_c) begin
          c_next     = C_PULSE;
          c_cnt_next = CW'(COIN_FRAMES);
        end
      end
      C_PULSE: begin
        if (c_cnt == '0) begin
          c_next = C_LOCK;
        end else if (frame_c) begin
          c_cnt_next = c_cnt - CW'(1);
          if (c_cnt == CW'(1)) c_next = C_LOCK;
        end
      end
      C_LOCK: begin
        if (!deb[J_COIN]) c_next = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Mode 2 FSM: reverse when the stick opposes the facing, then thrust
  always_comb begin
    m_next    = m_state;
    rcnt_next = rcnt;
    wcnt_next = wcnt;
    if ((mode != MODE2) || (mode != mode_d)) begin
      m_next = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (dir_opp_c) begin
            m_next    = M_REV;
            rcnt_next = RW'(REV_FRAMES);
          end else if (dir_match_c) begin
            m_next = M_THRUST;
          end
        end
        M_REV: begin
          if (rcnt == '0) begin
            m_next    = M_WAIT;
            wcnt_next = WW'(WAIT_FRAMES);
          end else if (frame_c) begin
            rcnt_next = rcnt - RW'(1);
            if (rcnt == RW'(1)) begin
              m_next    = M_WAIT;
              wcnt_next = WW'(WAIT_FRAMES);
            end
          end
        end
        M_WAIT: begin
          if (dir_match_c) begin
            m_next = M_THRUST;
          end else if ((dir_c == NONE) || (wcnt == '0)) begin
            m_next = M_IDLE;
          end else if (frame_c) begin
            wcnt_next = wcnt - WW'(1);
            if (wcnt == WW'(1)) m_next = M_IDLE;
          end
        end
        M_THRUST: begin
          if (dir_c == NONE) begin
            m_next = M_IDLE;
          end else if (dir_opp_c) begin
            m_next    = M_REV;
            rcnt_next = RW'(REV_FRAMES);
          end
        end
        default: m_next = M_IDLE;
      endcase
    end
  end

  // Thrust / reverse source per control mode; outputs follow the next state
  always_comb begin
    thrust_c = deb[J_R] | deb[J_L];
    rev_c    = deb[J_FIRE_B];
    case (mode)
      MODE2: begin
        thrust_c = (m_next == M_THRUST) && dir_match_c;
        rev_c    = (m_next == M_REV);
      end
      CABINET: begin
        thrust_c = deb[J_FIRE_E];
        rev_c    = deb[J_FIRE_B];
      end
      default: ;
    endcase
  end

  assign in0_c = {3'b000, (c_next == C_PULSE), deb[J_HSRESET], 1'b0,
                  deb[J_ADVANCE], deb[J_AUTOUP]};
  assign in1_c = {deb[J_D], thrust_c, deb[J_START1], deb[J_START2],
                  deb[J_FIRE_D], deb[J_FIRE_C], rev_c, deb[J_FIRE_A]};
  assign in2_c = {7'b0000000, deb[J_U]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_d <= 1'b0;
      coin_d   <= 1'b0;
      mode_d   <= MODE1;
      c_state  <= C_IDLE;
      c_cnt    <= '0;
      m_state  <= M_IDLE;
      rcnt     <= '0;
      wcnt     <= '0;
      in0      <= 8'h00;
      in1      <= 8'h00;
      in2      <= 8'h00;
    end else begin
      vblank_d <= vblank;
      coin_d   <= deb[J_COIN];
      mode_d   <= mode;
      c_state  <= c_next;
      c_cnt    <= c_cnt_next;
      m_state  <= m_next;
      rcnt     <= rcnt_next;
      wcnt     <= wcnt_next;
      in0      <= in0_c;
      in1      <= in1_c;
      in2      <= in2_c;
    end
  end

endmodule

// File: tb/tb_defender_input_cond.sv
module tb_defender_input_cond;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joy;
  logic [1:0]  mode;
  logic        facing_right;
  logic        vblank;
  logic [7:0]  in0, in1, in2;

  int errors = 0;
  int checks = 0;

  // Event counters maintained by the monitor
  int coin_frames = 0, coin_pulses = 0;
  int rev_frames = 0, norev_frames = 0, thr_cycles = 0;
  bit vb_prev = 1'b0, coin_prev = 1'b0;

  defender_input_cond #(
    .DEB_BITS    (4),
    .COIN_FRAMES (3),
    .REV_FRAMES  (2),
    .WAIT_FRAMES (8)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .joy          (joy),
    .mode         (mode),
    .facing_right (facing_right),
    .vblank       (vblank),
    .in0          (in0),
    .in1          (in1),
    .in2          (in2)
  );

  always #5 clk_sys = ~clk_sys;

  // Free-running vblank: 20-clock frames, changed just after posedge
  initial begin
    vblank = 1'b0;
    forever begin
      repeat (16) @(posedge clk_sys);
      #2 vblank = 1'b1;
      repeat (4) @(posedge clk_sys);
      #2 vblank = 1'b0;
    end
  end

  // Frame / pulse bookkeeping at the falling edge
  always @(negedge clk_sys) begin
    bit frame_now;
    frame_now = vblank && !vb_prev;
    vb_prev   = vblank;
    if (frame_now && in0[4] === 1'b1) coin_frames++;
    if (frame_now && in1[1] === 1'b1) rev_frames++;
    if (frame_now && in1[1] === 1'b0) norev_frames++;
    if (in1[6] === 1'b1) thr_cycles++;
    if (in0[4] === 1'b1 && !coin_prev) coin_pulses++;
    coin_prev = (in0[4] === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic watched(input int sel);
    case (sel)
      0:       return in1[1];
      1:       return in1[0];
      2:       return in0[4] & in1[1];
      default: return in0[4];
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (watched(sel) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference mapping for Mode 1 / Cabinet with coin idle: {in2, in1, in0}
  function automatic logic [23:0] ref_map(input logic [15:0] j, input logic [1:0] m);
    logic thr;
    logic [7:0] e0, e1, e2;
    thr = (m == 2'b10) ? j[8] : (j[0] | j[1]);
    e0  = {3'b000, 1'b0, j[14], 1'b0, j[12], j[13]};
    e1  = {j[2], thr, j[9], j[10], j[7], j[6], j[5], j[4]};
    e2  = {7'b0000000, j[3]};
    return {e2, e1, e0};
  endfunction

  initial begin
    bit ok, seen;
    int p0, f0, r0, n0, t0;
    logic [23:0] exp_v;
    logic [1:0]  m_r;
    logic [15:0] j_r;

    reset = 1'b1; joy = 16'hFFFF; mode = 2'b00; facing_right = 1'b1;

    // Reset: outputs held at zero through reset and the two debounce ticks
    step(3);
    chk("reset_in0", 32'(in0), 32'h00);
    chk("reset_in1", 32'(in1), 32'h00);
    chk("reset_in2", 32'(in2), 32'h00);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      if (in0 !== 8'h00 || in1 !== 8'h00 || in2 !== 8'h00) seen = 1'b1;
    end
    chk("post_reset_zero", 32'(seen), 32'd0);
    step(1);
    chk("first_in0", 32'(in0), 32'h1B);
    chk("first_in1", 32'(in1), 32'hFF);
    chk("first_in2", 32'(in2), 32'h01);
    joy = 16'h0000;
    step(120);
    chk("idle_in0", 32'(in0), 32'h00);

    // Glitch rejection on fire_a
    joy = 16'h0010;
    step(10);
    joy = 16'h0000;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (in1[0] !== 1'b0) seen = 1'b1;
    end
    chk("glitch_fire_a", 32'(seen), 32'd0);
    joy = 16'h0010;
    wait_for(1, 1'b1, 34, ok);
    chk("hold_fire_a", 32'(ok), 32'd1);
    step(8);
    joy = 16'h0000;
    step(40);

    // Coin: held press gives one 3-frame pulse; re-press gives another
    for (int r = 0; r < 2; r++) begin
      p0 = coin_pulses; f0 = coin_frames;
      joy = 16'h0800;
      step(200);
      chk("coin_pulses", 32'(coin_pulses - p0), 32'd1);
      chk("coin_frames", 32'(coin_frames - f0), 32'd3);
      chk("coin_low_held", 32'(in0[4]), 32'd0);
      joy = 16'h0000;
      step(60);
    end

    // Mode 2: reverse then thrust after the facing flips
    mode = 2'b01; facing_right = 1'b1;
    step(5);
    r0 = rev_frames;
    joy = 16'h0002;
    wait_for(0, 1'b1, 40, ok);
    chk("m2_rev_start", 32'(ok), 32'd1);
    chk("m2_rev_nothrust", 32'(in1[6]), 32'd0);
    wait_for(0, 1'b0, 100, ok);
    chk("m2_rev_end", 32'(ok), 32'd1);
    chk("m2_rev_frames", 32'(rev_frames - r0), 32'd2);
    facing_right = 1'b0;
    step(1);
    chk("m2_thrust_flip", 32'(in1[6]), 32'd1);
    step(25);
    chk("m2_thrust_hold", 32'(in1[7:6]), 32'd1);
    chk("m2_thrust_norev", 32'(in1[1]), 32'd0);
    joy = 16'h0000;
    step(40);
    chk("m2_release", 32'(in1[6]), 32'd0);
    facing_right = 1'b1;
    step(2);

    // Mode 2 without the flip: wait times out, thrust never asserts
    r0 = rev_frames;
    joy = 16'h0002;
    wait_for(0, 1'b1, 40, ok);
    chk("m2b_rev_start", 32'(ok), 32'd1);
    wait_for(0, 1'b0, 100, ok);
    chk("m2b_rev_end", 32'(ok), 32'd1);
    chk("m2b_rev_frames", 32'(rev_frames - r0), 32'd2);
    n0 = norev_frames; t0 = thr_cycles;
    wait_for(0, 1'b1, 250, ok);
    chk("m2b_rev_again", 32'(ok), 32'd1);
    chk("m2b_wait_frames", 32'(norev_frames - n0), 32'd8);
    chk("m2b_no_thrust", 32'(thr_cycles - t0), 32'd0);

    // Mode switch during reverse falls back to Mode 1 mapping next clock
    mode = 2'b00;
    step(1);
    chk("msw_rev_b", 32'(in1[1]), 32'd0);
    chk("msw_thrust", 32'(in1[6]), 32'd1);

    // Cabinet: thrust from fire_e only
    mode = 2'b10; joy = 16'h0003;
    step(40);
    chk("cab_stick", 32'(in1), 32'h00);
    joy = 16'h0100;
    step(40);
    chk("cab_fire_e", 32'(in1), 32'h40);

    // Randomized mapping in Mode 1 / Cabinet / mode 11
    for (int r = 0; r < 16; r++) begin
      case ($urandom_range(0, 2))
        0:       m_r = 2'b00;
        1:       m_r = 2'b10;
        default: m_r = 2'b11;
      endcase
      j_r = 16'($urandom()) & 16'hF7FF;
      mode = m_r; joy = j_r;
      step(40);
      exp_v = ref_map(j_r, m_r);
      chk("rand_in0", 32'(in0), 32'(exp_v[7:0]));
      chk("rand_in1", 32'(in1), 32'(exp_v[15:8]));
      chk("rand_in2", 32'(in2), 32'(exp_v[23:16]));
    end

    // Reset mid-pulse drops coin and rev_b on the next clock
    joy = 16'h0000; mode = 2'b00;
    step(40);
    mode = 2'b01; facing_right = 1'b1; joy = 16'h0802;
    wait_for(2, 1'b1, 40, ok);
    chk("rst_pulse_start", 32'(ok), 32'd1);
    reset = 1'b1;
    step(1);
    chk("rst_mid_in0", 32'(in0), 32'h00);
    chk("rst_mid_in1", 32'(in1), 32'h00);
    reset = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/defender_input_cond.md
# defender_input_cond

Input-conditioning stage that sits directly upstream of the Defender core's `input0`/`input1`/`input2` ports and replaces the combinational joystick-to-switch mapping. It takes merged MiSTer joystick bits and produces the three registered Defender input bytes. Processing steps:
- debounces all buttons;
- stretches coin presses to a frame-counted pulse;
- implements "Mode 2" control, where the stick direction drives automatic Reverse and Thrust based on the ship's facing.

## Interface
Parameters:
- `DEB_BITS`, 16: debounce prescaler width; sample tick every 2^DEB_BITS clocks.
- `COIN_FRAMES`, 3: coin output high time, in frames.
- `REV_FRAMES`, 2: Reverse pulse width, in frames.
- `WAIT_FRAMES`, 8: maximum frames to wait for the facing to flip after a Reverse.

Ports:
- `clk_sys`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous reset, active-high.
- `joy`  in  16  raw merged joystick, active-high:
  - 0 R, 1 L, 2 D, 3 U;
  - 4..8 fire A..E;
  - 9 start1, 10 start2, 11 coin, 12 advance, 13 auto-up, 14 high-score reset, 15 pause (ignored).
- `mode`  in  2  control mode: 00 Mode 1, 01 Mode 2, 10 Cabinet, 11 treated as Mode 1.
- `facing_right`  in  1  ship facing from the core, synchronous to `clk_sys`.
- `vblank`  in  1  video vblank, synchronous; its rising edge is the frame tick.
- `in0`  out  8  {3'b000, coin, hs_reset, 1'b0, advance, autoup}.
- `in1`  out  8  {down, thrust, start1, start2, fire_d, fire_c, rev_b, fire_a}.
- `in2`  out  8  {7'b0, up}.

## Operation
- **Debounce**
  - A free-running prescaler produces a one-cycle `tick` when the counter wraps to 0.
  - At each tick all 16 raw bits are sampled.
  - A debounced bit takes the new value only when two consecutive samples agree.
  - Reset clears the samples, the debounced state and the prescaler.
- **Frame tick**
  - `frame` = `vblank` & ~`vblank_d`, where `vblank_d` is `vblank` delayed by one clock.
- **Coin FSM** (states C_IDLE, C_PULSE, C_LOCK)
  - C_IDLE: on a debounced coin rising edge, load `cnt`=COIN_FRAMES and go to C_PULSE.
  - C_PULSE: coin output = 1. Decrement `cnt` on each frame; at 0 go to C_LOCK.
  - C_LOCK: coin output = 0. Stay until debounced coin = 0, then return to C_IDLE.
  - Holding coin therefore yields exactly one pulse.
- **Direction**
  - `dir_req` = R&~L → RIGHT; L&~R → LEFT; both or neither → NONE.
- **Mode 2 FSM** (states M_IDLE, M_REV, M_WAIT, M_THRUST)
  - M_IDLE:
    - `dir_req` ≠ NONE and opposite to `facing_right` → M_REV, load `rcnt`=REV_FRAMES.
    - `dir_req` equal to facing → M_THRUST.
  - M_REV: `rev_b`=1. Decrement `rcnt` on each frame; at 0 → M_WAIT, load `wcnt`=WAIT_FRAMES.
  - M_WAIT:
    - facing now matches `dir_req` → M_THRUST.
    - `wcnt` reaches 0 or `dir_req`=NONE → M_IDLE.
  - M_THRUST: thrust=1 while `dir_req` matches facing.
    - `dir_req`=NONE → M_IDLE.
    - `dir_req` opposite → M_REV.
  - `mode` ≠ 01, or any change of `mode`, forces M_IDLE on the next clock.
- **Bit mapping**
  - Mode 1: thrust = L|R; rev_b = fire_b.
  - Mode 2: thrust and rev_b come from the FSM.
  - Cabinet: thrust = fire_e; rev_b = fire_b.
  - All other bits map directly from debounced `joy`.

## Timing
- All outputs are registered and reset to 8'h00. FSMs reset to C_IDLE and M_IDLE.
- Raw edge to debounced change:
  - minimum 2^DEB_BITS+1 clocks;
  - maximum 2·2^DEB_BITS+1 clocks;
  - plus 1 clock of output register.
- Frame-driven transitions take effect one clock after the `vblank` rising edge.
- A frame tick and a state-entry condition in the same clock: the entry wins. The counter loads and is not decremented that cycle.
- Reset asserted mid-pulse drops coin and rev_b on the next clock.
- Counter widths are $clog2(param+1). Counters never underflow: a decrement at 0 is ignored.

## Structure
- `defender_input_pkg` holds:
  - mode encodings (MODE1, MODE2, CABINET);
  - `joy` bit indices;
  - the `dir_t` enum (NONE, LEFT, RIGHT);
  - FSM state typedefs.
- Sub-module `debounce_bank` (parameter W=16, DEB_BITS) contains the prescaler and sample/agree logic.
- The top contains the coin FSM, the Mode 2 FSM and the output mapping.

## Test plan
- **Reset:** hold `reset` 3 clocks with `joy`=16'hFFFF → `in0`/`in1`/`in2` = 00 until 2 ticks after release. Use DEB_BITS=4.
- **Glitch rejection:** a fire_a pulse of 10 clocks with DEB_BITS=4 → `in1[0]` never sets. A 40-clock hold → `in1[0]`=1 within 33 clocks.
- **Coin:** hold coin for 10 frames → `in0[4]` high for exactly 3 frames, then 0. Release and re-press → exactly one more 3-frame pulse.
- **Mode 2 reverse:** `facing_right`=1, then press L → `in1[1]`=1 for 2 frames.
  - Flip `facing_right` to 0 in the first M_WAIT frame → `in1[6]`=1 while L is held.
  - Without the flip → M_IDLE after 8 frames and thrust stays 0.
- **Mode switch:** switch `mode` 01→00 during M_REV → `in1[1]` follows fire_b and `in1[6]`=L|R on the next clock.
- **Cabinet:** fire_e pressed → `in1[6]`=1. Stick L|R is ignored for thrust.
